ws2812: RTL and testbench

- Drives a chain of WS2812 addressable RGB LEDs from a single serial output pin.
- Holds one 24-bit colour register per LED and lets the host write one colour into any subset of LEDs at once, selected by a bit mask.
- Refreshes the whole chain continuously: a latch/reset low period, then every LED's 24 bits, then repeat.
- Sits between a host/controller and the LED strip data pin.

---
 rtl/ws2812.sv | 166 ++++++++++++++++
 tb/tb_ws2812.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ws2812 - continuous refresh driver for a chain of WS2812 RGB LEDs.
//
// Holds one 24-bit colour per LED. The host writes one colour into any subset
// of LEDs through a bit mask. The chain is refreshed forever: a T_RESET low
// latch period, then every LED's 24 bits, from LED NUM_LEDS-1 down to LED 0.
// Each LED is sent in GRB order, MSB first.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   rgb_colour  colour to write, {R, G, B}
//   led_mask    bit i selects LED i for the write
//   write       write strobe
//   data        serial WS2812 data line (registered)
//   frame_done  one-cycle pulse at the end of each frame
//               (present only with WS2812_FRAME_DONE_EN defined)
//
// Optional feature macro: WS2812_FRAME_DONE_EN
// ---------------------------------------------------------------------------
module ws2812 #(
  parameter int NUM_LEDS = 4,
  parameter int T_ON_1   = 9,
  parameter int T_ON_0   = 4,
  parameter int T_PERIOD = 15,
  parameter int T_RESET  = 600
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [23:0]         rgb_colour,
  input  logic [NUM_LEDS-1:0] led_mask,
  input  logic                write,
`ifdef WS2812_FRAME_DONE_EN
  output logic                data,
  output logic                frame_done
`else
  output logic                data
`endif
);

  localparam int LW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CMAX = (T_RESET > T_PERIOD) ? T_RESET : T_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {
    STATE_RESET = 1'b0,
    STATE_DATA  = 1'b1
  } state_t;

  state_t         r_state;
  logic [23:0]    r_led_reg [NUM_LEDS];
  logic [23:0]    r_shift;
  logic [LW-1:0]  r_led_counter;
  logic [4:0]     r_bit_cnt;
  logic [CW-1:0]  r_cycle_cnt;
  logic           r_data;
`ifdef WS2812_FRAME_DONE_EN
  logic           r_frame_done;
`endif

  logic [CW-1:0]  w_cycle_nxt;
  logic [CW-1:0]  w_ton;
  logic           w_last_cycle;
  logic           w_reset_done;
  logic [LW-1:0]  w_next_idx;

  // Reorder {R,G,B} into wire order {G,R,B} so the shifter can send MSB first.
  function automatic logic [23:0] grb_order(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  assign w_cycle_nxt  = r_cycle_cnt + CW'(1);
  assign w_ton        = r_shift[23] ? CW'(T_ON_1) : CW'(T_ON_0);
  assign w_last_cycle = (r_cycle_cnt == CW'(T_PERIOD - 1));
  assign w_reset_done = (r_cycle_cnt == CW'(T_RESET - 1));
  assign w_next_idx   = r_led_counter - LW'(1);

  assign data = r_data;
`ifdef WS2812_FRAME_DONE_EN
  assign frame_done = r_frame_done;
`endif

  // Colour register file: masked write, accepted in any refresh state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_led_reg[i] <= 24'h000000;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (write && led_mask[i]) begin
          r_led_reg[i] <= rgb_colour;
        end
      end
    end
  end

  // Refresh FSM: latch period, then per-bit PWM with a registered data line.
  // r_data always holds the level for the cycle the counters will be in next,
  // so the pin is glitch-free and exactly aligned with the bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= STATE_RESET;
      r_shift       <= 24'h000000;
      r_led_counter <= LW'(NUM_LEDS - 1);
      r_bit_cnt     <= 5'd0;
      r_cycle_cnt   <= {CW{1'b0}};
      r_data        <= 1'b0;
`ifdef WS2812_FRAME_DONE_EN
      r_frame_done  <= 1'b0;
`endif
    end else begin
`ifdef WS2812_FRAME_DONE_EN
      r_frame_done <= 1'b0;
`endif
      case (r_state)
        STATE_RESET: begin
          r_data <= 1'b0;
          if (w_reset_done) begin
            // Latch the first LED's colour at the start of its slot; both
            // high times are non-zero so every bit starts with data high.
            r_state       <= STATE_DATA;
            r_shift       <= grb_order(r_led_reg[NUM_LEDS-1]);
            r_led_counter <= LW'(NUM_LEDS - 1);
            r_bit_cnt     <= 5'd23;
            r_cycle_cnt   <= {CW{1'b0}};
            r_data        <= 1'b1;
          end else begin
            r_cycle_cnt <= w_cycle_nxt;
          end
        end
        STATE_DATA: begin
          if (w_last_cycle) begin
            r_cycle_cnt <= {CW{1'b0}};
            if (r_bit_cnt != 5'd0) begin
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
              r_data    <= 1'b1;
            end else if (r_led_counter != {LW{1'b0}}) begin
              r_led_counter <= w_next_idx;
              r_shift       <= grb_order(r_led_reg[w_next_idx]);
              r_bit_cnt     <= 5'd23;
              r_data        <= 1'b1;
            end else begin
              r_state      <= STATE_RESET;
              r_data       <= 1'b0;
`ifdef WS2812_FRAME_DONE_EN
              r_frame_done <= 1'b1;
`endif
            end
          end else begin
            r_cycle_cnt <= w_cycle_nxt;
            r_data      <= (w_cycle_nxt < w_ton);
          end
        end
        default: begin
          r_state     <= STATE_RESET;
          r_cycle_cnt <= {CW{1'b0}};
          r_data      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812.sv
`timescale 1ns/1ps
module tb_ws2812;

  localparam int TP = 15;

  logic        clk;
  logic        reset;
  logic [23:0] rgb_colour;
  logic [3:0]  led_mask;
  logic        write;
  logic        data;
`ifdef WS2812_FRAME_DONE_EN
  logic        frame_done;
  int          fd_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  ws2812 dut (
    .clk        (clk),
    .reset      (reset),
    .rgb_colour (rgb_colour),
    .led_mask   (led_mask),
    .write      (write),
`ifdef WS2812_FRAME_DONE_EN
    .data       (data),
    .frame_done (frame_done)
`else
    .data       (data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WS2812_FRAME_DONE_EN
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end
`endif

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count low samples until data rises (bounded); n = -1 on timeout.
  task automatic wait_rise(input int start, output int n);
    bit seen;
    seen = 1'b0;
    n = start;
    for (int k = 0; k < 5000; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (data === 1'b1) seen = 1'b1;
        else n++;
      end
    end
    if (!seen) n = -1;
  endtask

  // Decode nbits bit periods from the pin, 15 negedge samples per bit.
  // Optionally holds a write asserted across bit 10 of this slot.
  task automatic read_led(input bit skip, input int nbits, input bit do_wr,
                          input logic [3:0] wm, input logic [23:0] wc,
                          output logic [23:0] val, output int terr);
    int h;
    int lo;
    val  = 24'h000000;
    terr = 0;
    for (int b = 0; b < nbits; b++) begin
      if (!(skip && b == 0)) @(negedge clk);
      if (do_wr && b == 10) begin
        led_mask = wm; rgb_colour = wc; write = 1'b1;
      end
      if (do_wr && b == 11) write = 1'b0;
      if (data !== 1'b1) terr++;
      h = 1; lo = 0;
      for (int k = 1; k < TP; k++) begin
        @(negedge clk);
        if (data === 1'b1) begin
          if (lo != 0) terr++;
          else h++;
        end else begin
          lo++;
        end
      end
      if (h == 9) val = {val[22:0], 1'b1};
      else if (h == 4) val = {val[22:0], 1'b0};
      else terr++;
    end
  endtask

  logic [23:0] v;
  int          te;
  int          n;
  time         t_f1;
  time         t_f2;

  initial begin
    reset = 1'b0; write = 1'b0; led_mask = 4'b0000; rgb_colour = 24'h000000;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_data", 96'(data), 96'd0);
    check("rst_state", 96'(dut.r_state), 96'd0);
    check("rst_regs", {dut.r_led_reg[3], dut.r_led_reg[2], dut.r_led_reg[1], dut.r_led_reg[0]}, 96'd0);

    // Release reset together with a masked write to LEDs 0 and 2.
    @(posedge clk); #1;
    reset = 1'b1; write = 1'b1; led_mask = 4'b0101; rgb_colour = 24'hAACCDD;
    @(posedge clk); #1;
    write = 1'b0;
    @(negedge clk);
    check("masked_write", {dut.r_led_reg[3], dut.r_led_reg[2], dut.r_led_reg[1], dut.r_led_reg[0]},
          96'h000000_AACCDD_000000_AACCDD);
    wait_rise(2, n);
    check("first_low_len", 96'(n), 96'd600);
    check("state_data", 96'(dut.r_state), 96'd1);
    t_f1 = $time;

    // Frame 1: write LED0 during LED2's slot (same frame), and again during
    // LED0's own slot (next frame only).
    read_led(1'b1, 24, 1'b0, 4'b0000, 24'h000000, v, te);
    check("f1_led3", 96'(v), 96'h000000); check("f1_led3_timing", 96'(te), 96'd0);
    read_led(1'b0, 24, 1'b1, 4'b0001, 24'h00FF00, v, te);
    check("f1_led2", 96'(v), 96'hCCAADD); check("f1_led2_timing", 96'(te), 96'd0);
    read_led(1'b0, 24, 1'b0, 4'b0000, 24'h000000, v, te);
    check("f1_led1", 96'(v), 96'h000000); check("f1_led1_timing", 96'(te), 96'd0);
    read_led(1'b0, 24, 1'b1, 4'b0001, 24'h123456, v, te);
    check("f1_led0", 96'(v), 96'hFF0000); check("f1_led0_timing", 96'(te), 96'd0);

    // Latch gap: frame_done pulse, then a write with an empty mask.
    @(negedge clk);
`ifdef WS2812_FRAME_DONE_EN
    check("fd_pulse", 96'(frame_done), 96'd1);
`endif
    check("gap_data", 96'(data), 96'd0);
    write = 1'b1; led_mask = 4'b0000; rgb_colour = 24'hFFFFFF;
    @(negedge clk);
`ifdef WS2812_FRAME_DONE_EN
    check("fd_one_cycle", 96'(frame_done), 96'd0);
`endif
    write = 1'b0;
    @(negedge clk);
    check("zero_mask", {dut.r_led_reg[3], dut.r_led_reg[2], dut.r_led_reg[1], dut.r_led_reg[0]},
          96'h000000_AACCDD_000000_123456);
    wait_rise(3, n);
    check("f1_gap_len", 96'(n), 96'd600);
    t_f2 = $time;
    check("frame_len_ns", 96'(t_f2 - t_f1), 96'd20400);

    // Frames 2..6: steady refresh with the updated LED0 colour.
    for (int f = 2; f <= 6; f++) begin
      read_led(1'b1, 24, 1'b0, 4'b0000, 24'h000000, v, te);
      check("fx_led3", 96'(v), 96'h000000);
      read_led(1'b0, 24, 1'b0, 4'b0000, 24'h000000, v, te);
      check("fx_led2", 96'(v), 96'hCCAADD);
      read_led(1'b0, 24, 1'b0, 4'b0000, 24'h000000, v, te);
      check("fx_led1", 96'(v), 96'h000000);
      read_led(1'b0, 24, 1'b0, 4'b0000, 24'h000000, v, te);
      check("fx_led0", 96'(v), 96'h341256);
      check("fx_timing", 96'(te), 96'd0);
      wait_rise(0, n);
      check("fx_gap_len", 96'(n), 96'd600);
    end

    // Frame 7: reset asserted at the start of LED1 bit 5.
    read_led(1'b1, 24, 1'b0, 4'b0000, 24'h000000, v, te);
    read_led(1'b0, 24, 1'b0, 4'b0000, 24'h000000, v, te);
    check("f7_led2", 96'(v), 96'hCCAADD);
    read_led(1'b0, 5, 1'b0, 4'b0000, 24'h000000, v, te);
    @(negedge clk);
    check("b5_high", 96'(data), 96'd1);
    reset = 1'b0;
    #1;
    check("async_rst_data", 96'(data), 96'd0);
    check("async_rst_state", 96'(dut.r_state), 96'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_rise(0, n);
    check("post_rst_low_len", 96'(n), 96'd600);
    for (int l = 3; l >= 0; l--) begin
      read_led(l == 3, 24, 1'b0, 4'b0000, 24'h000000, v, te);
      check("post_rst_led", 96'(v), 96'h000000);
      check("post_rst_timing", 96'(te), 96'd0);
    end
    @(negedge clk);
    #1;
    check("end_data", 96'(data), 96'd0);
`ifdef WS2812_FRAME_DONE_EN
    check("fd_count", 96'(fd_cnt), 96'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
